// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8-entry byte FIFO feeding an 8E1 UART transmitter.
// Frame = start(0), 8 data bits LSB first, even parity, stop(1).
// Every output is a register; next values are formed combinationally.
module uart_tx_fifo #(
  parameter int CYCLES_PER_BIT = 14,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk_3125,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_wr,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          tx_overflow,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic          push, pop;
  logic [7:0]    head;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          bit_end;

  // Status flags come straight from the registered count.
  assign tx_full     = (count_reg == DEPTH_L);
  assign tx_empty    = (count_reg == '0);
  assign tx_level    = count_reg;
  assign tx_overflow = overflow_reg;
  assign tx          = tx_reg;
  assign tx_busy     = busy_reg;
  assign tx_done     = done_reg;

  // A write is judged against the count before this edge, so a same-edge pop
  // cannot rescue a write into a full FIFO.
  assign push    = tx_wr && !tx_full;
  assign head    = mem[rd_ptr_reg];
  assign bit_end = (cnt_reg == BIT_LAST);

  // FIFO storage: data is captured on the accepting edge.
  always_ff @(posedge clk_3125) begin
    if (push) mem[wr_ptr_reg] <= tx_data;
  end

  // FIFO pointers, occupancy count and overflow pulse.
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      overflow_reg <= tx_wr && tx_full;
    end
  end

  // Transmitter state and registered serial outputs.
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // Next-state logic; tx for the coming cycle is chosen from the next state so
  // the line changes on the same edge as the state.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + 1'b1;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    done_next   = 1'b0;
    pop         = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!tx_empty) begin
          pop         = 1'b1;
          shift_next  = head;
          parity_next = ^head;
          state_next  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next  = '0;
          done_next = 1'b1;
          if (!tx_empty) begin
            // Chain straight into the next start bit: no idle gap.
            pop         = 1'b1;
            shift_next  = head;
            parity_next = ^head;
            state_next  = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: bit-exact frame checks, FIFO level and
// overflow behaviour, mid-frame reset, and a mid-bit sampling receiver fed
// with random bytes.
module tb_uart_tx_fifo;

  logic       clk_3125 = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full, tx_empty, tx_overflow, tx, tx_busy, tx_done;
  logic [3:0] tx_level;

  int tests = 0;
  int fails = 0;

  always #5 clk_3125 = ~clk_3125;

  uart_tx_fifo #(.CYCLES_PER_BIT(14), .FIFO_DEPTH(8)) dut (
    .clk_3125    (clk_3125),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_full     (tx_full),
    .tx_empty    (tx_empty),
    .tx_level    (tx_level),
    .tx_overflow (tx_overflow),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk_3125);
    #1;
  endtask

  task automatic write1(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    tick;
    tx_wr   = 1'b0;
  endtask

  // Called 'skip' cycles after the start edge; checks the rest of the frame
  // cycle by cycle and ends just after the stop-bit-ending edge.
  task automatic expect_frame(input logic [7:0] b, input logic par, input int skip);
    logic [10:0] bits;
    bits = {1'b1, par, b, 1'b0};
    for (int n = skip; n < 154; n++) begin
      check($sformatf("tx_bit%0d_of_%02h", n / 14, b), tx, bits[n / 14]);
      if (n != 0) check("done_mid_frame", tx_done, 1'b0);
      tick;
    end
    check($sformatf("done_end_%02h", b), tx_done, 1'b1);
    $display("[TB] frame %02h checked", b);
  endtask

  // Mid-bit sampling receiver; waits (bounded) for a start bit.
  task automatic rx_byte(input logic [7:0] sent);
    int         w;
    logic [7:0] d;
    logic       p, stp;
    w = 0;
    while (tx !== 1'b0 && w < 300) begin
      tick;
      w++;
    end
    check("rx_start_seen", (w < 300), 1'b1);
    repeat (7) tick;
    check("rx_start_mid", tx, 1'b0);
    for (int j = 0; j < 8; j++) begin
      repeat (14) tick;
      d[j] = tx;
    end
    repeat (14) tick;
    p = tx;
    repeat (14) tick;
    stp = tx;
    check("rx_data", d, sent);
    check("rx_even_parity", ^{d, p}, 1'b0);
    check("rx_stop", stp, 1'b1);
    repeat (7) tick;
    check("rx_done", tx_done, 1'b1);
    $display("[TB] rx sent %02h got %02h", sent, d);
  endtask

  logic [7:0] ten_b [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                             8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
  logic       ten_p [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int         highs, dones;
    logic [7:0] rb;

    // Reset state
    rst = 1'b1; tx_wr = 1'b0; tx_data = 8'h00;
    tick; tick;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_ovf", tx_overflow, 1'b0);
    check("rst_full", tx_full, 1'b0);
    check("rst_empty", tx_empty, 1'b1);
    check("rst_level", tx_level, 4'd0);
    rst = 1'b0;
    tick;

    // Single byte 0xA5 from idle
    write1(8'hA5);
    check("a5_empty_after_wr", tx_empty, 1'b0);
    check("a5_level_after_wr", tx_level, 4'd1);
    check("a5_tx_idle", tx, 1'b1);
    tick;
    check("a5_busy_rise", tx_busy, 1'b1);
    check("a5_level_after_pop", tx_level, 4'd0);
    expect_frame(8'hA5, 1'b0, 0);
    check("a5_busy_fall", tx_busy, 1'b0);
    check("a5_empty_end", tx_empty, 1'b1);
    tick;
    check("a5_done_one_cycle", tx_done, 1'b0);

    // Parity corner cases
    write1(8'h07); tick;
    expect_frame(8'h07, 1'b1, 0);
    tick;
    write1(8'h00); tick;
    expect_frame(8'h00, 1'b0, 0);
    tick;

    // Three consecutive writes: contiguous frames
    tx_wr = 1'b1;
    tx_data = 8'h11; tick; check("lvl_seq0", tx_level, 4'd1);
    tx_data = 8'h22; tick; check("lvl_seq1", tx_level, 4'd1);
    tx_data = 8'h33; tick; check("lvl_seq2", tx_level, 4'd2);
    tx_wr = 1'b0;
    expect_frame(8'h11, 1'b0, 1);
    expect_frame(8'h22, 1'b0, 0);
    expect_frame(8'h33, 1'b0, 0);
    check("three_busy_fall", tx_busy, 1'b0);
    check("three_empty", tx_empty, 1'b1);
    tick;

    // Ten consecutive writes: nine accepted, one overflow
    for (int i = 0; i < 10; i++) begin
      tx_data = ten_b[i];
      tx_wr   = 1'b1;
      tick;
      check($sformatf("ovf_after_wr%0d", i + 1), tx_overflow, (i == 9));
      check($sformatf("full_after_wr%0d", i + 1), tx_full, (i >= 8));
    end
    tx_wr = 1'b0;
    check("ten_level", tx_level, 4'd8);
    tick;
    check("ovf_single_pulse", tx_overflow, 1'b0);
    expect_frame(ten_b[0], ten_p[0], 9);
    for (int i = 1; i < 9; i++) expect_frame(ten_b[i], ten_p[i], 0);
    check("ten_busy_fall", tx_busy, 1'b0);
    check("ten_empty", tx_empty, 1'b1);
    tick;

    // Reset 50 cycles into a frame with three bytes queued
    write1(8'h5A); write1(8'h6B); write1(8'h7C); write1(8'h8D);
    check("rstmid_level", tx_level, 4'd3);
    repeat (48) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rstmid_tx", tx, 1'b1);
    check("rstmid_level0", tx_level, 4'd0);
    check("rstmid_busy", tx_busy, 1'b0);
    check("rstmid_empty", tx_empty, 1'b1);
    highs = 0; dones = 0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (tx === 1'b1) highs++;
      if (tx_done === 1'b1) dones++;
    end
    check("rstmid_tx_stays_high", highs, 200);
    check("rstmid_no_done", dones, 0);

    // Loopback through a sampling receiver with random bytes
    for (int i = 0; i < 256; i++) begin
      rb = 8'($urandom_range(0, 255));
      write1(rb);
      rx_byte(rb);
    end
    tick;
    check("final_idle", tx_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side UART for the colour-sensor link. It buffers bytes from the sensor/formatting logic in an 8-entry FIFO and serialises each one onto `tx` as a start bit, 8 data bits LSB first, an even-parity bit and a stop bit. This framing and bit rate match the team's `uart_rx` receiver, so the two blocks loop back cleanly. It sits between the message formatter and the board TX pin.

## Interface
Parameters:
- `CYCLES_PER_BIT`, 14: clocks per serial bit (≈230,400 bps at 3.125 MHz).
- `FIFO_DEPTH`, 8: FIFO entries. Must be a power of 2, ≥2.

Ports:
- `clk_3125`  in  1: 3.125 MHz system clock. One clock domain, rising edge only.
- `rst`  in  1: synchronous, active-high reset.
- `tx_data`  in  8: byte to enqueue.
- `tx_wr`  in  1: write strobe. Accepted on any edge where `tx_full`=0.
- `tx_full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `tx_empty`  out  1: FIFO holds 0 entries.
- `tx_level`  out  $clog2(FIFO_DEPTH)+1: current entry count.
- `tx_overflow`  out  1: one-cycle pulse when a write is dropped.
- `tx`  out  1: serial line, idles high.
- `tx_busy`  out  1: high while the FSM is in any state other than IDLE.
- `tx_done`  out  1: one-cycle pulse at the end of each frame.

## Operation
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`, plus a registered count.
  - `tx_full`, `tx_empty` and `tx_level` are derived from the registered count.
  - A write with `tx_full`=1 is dropped and pulses `tx_overflow`. This holds even if a pop occurs on the same edge.
  - A simultaneous accepted write and pop leaves the count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - `tx`=1.
  - If `tx_empty`=0: pop the FIFO head into the shift register, set parity = XOR of the 8 bits, and go to START.
- START: `tx`=0 for `CYCLES_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA:
  - `tx` = shift-register bit 0, held `CYCLES_PER_BIT` cycles.
  - Then shift right and increment the index.
  - After index 7, go to PARITY.
- PARITY: `tx` = parity bit for `CYCLES_PER_BIT` cycles. With even parity, the total number of ones across data plus parity is even.
- STOP:
  - `tx`=1 for `CYCLES_PER_BIT` cycles.
  - On the final cycle's edge, pulse `tx_done`.
  - If the FIFO is non-empty: pop and go directly to START, with no idle gap.
  - Otherwise go to IDLE.
- Bit counter width is ≥ $clog2(`CYCLES_PER_BIT`). It resets to 0 on every bit boundary.
- `tx_data` is captured at the write edge. The popped byte is captured at the pop edge. Later input changes do not affect a frame already in progress.

## Timing
- Reset values:
  - `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_overflow`=0.
  - `tx_full`=0, `tx_empty`=1, `tx_level`=0.
  - FSM in IDLE, pointers and count at 0.
- Reset mid-frame: the frame is aborted and the FIFO contents are discarded. `tx` is high from the reset edge onward.
- Latency, write to idle and empty block:
  - Write accepted at edge E: `tx_empty`=0 after E.
  - At edge E+1 the FIFO pops, the FSM enters START and `tx` goes low.
- Frame length is 11×`CYCLES_PER_BIT` = 154 cycles. `tx` low spans edges E+1 to E+15.
- `tx_done` is high for exactly the one cycle after edge E+155, which is the edge that ends the stop bit.
- `tx_busy` rises at E+1. It falls at E+155 only if no further data is queued.
- Back-to-back frames are contiguous: the next start bit begins on the same edge that ends the previous stop bit.

## Test plan
- Single byte 0xA5 from reset:
  - `tx` reads low×14, then 1,0,1,0,0,1,0,1 (14 cycles each), then parity 0, then stop high.
  - `tx_done` pulses 154 cycles after the start edge.
  - `tx_busy` then falls and `tx_empty`=1.
- Byte 0x07: parity bit = 1. Byte 0x00: parity bit = 0. Check both bit-accurately.
- Three writes (0x11, 0x22, 0x33) on consecutive cycles:
  - Frames are contiguous over 462 cycles with three `tx_done` pulses.
  - `tx_level` sequence begins 1, 1, 2.
- Ten writes on consecutive cycles to an idle block:
  - Writes 1–9 are accepted, because byte 1 pops at E+1.
  - Write 10 is dropped with a single `tx_overflow` pulse, and `tx_full`=1 after write 9.
  - Exactly 9 frames are transmitted in order.
- `rst` asserted 50 cycles into a frame with 3 bytes queued:
  - `tx`=1 from the reset edge and `tx_level`=0.
  - No `tx_done` pulse and no further frames.
- Loopback of `tx` into `uart_rx` with 256 random bytes: every `rx_msg` equals the sent byte, one `rx_complete` per byte, and no 0x3F substitution.
